// File: rtl/apf_keypad_matrix_pkg.sv
// Shared constants for the MP1000 keypad matrix: key indices, row layout,
// joystick bit positions and the PS/2 scancode-to-key lookup.
package apf_keypad_pkg;

  localparam int NUM_KEYS = 12;

  localparam logic [3:0] K0  = 4'd0;
  localparam logic [3:0] K1  = 4'd1;
  localparam logic [3:0] K2  = 4'd2;
  localparam logic [3:0] K3  = 4'd3;
  localparam logic [3:0] K4  = 4'd4;
  localparam logic [3:0] K5  = 4'd5;
  localparam logic [3:0] K6  = 4'd6;
  localparam logic [3:0] K7  = 4'd7;
  localparam logic [3:0] K8  = 4'd8;
  localparam logic [3:0] K9  = 4'd9;
  localparam logic [3:0] KCL = 4'd10;
  localparam logic [3:0] KEN = 4'd11;

  // Joystick bit positions inside each pad's 5-bit slice of joy.
  localparam int JOY_BITS  = 5;
  localparam int JOY_RIGHT = 0;
  localparam int JOY_LEFT  = 1;
  localparam int JOY_DOWN  = 2;
  localparam int JOY_UP    = 3;
  localparam int JOY_FIRE  = 4;

  localparam int ROW_KEYS_A = 0;
  localparam int ROW_JOY    = 1;
  localparam int ROW_KEYS_B = 2;
  localparam int ROW_KEYS_C = 3;
  localparam int DEF_ROWS   = 4;

  // Nibble layouts, element [3] is column bit 3 of the pad's nibble.
  localparam logic [3:0][3:0] ROW0_KEYS = {K7, K4, K0, K1};
  localparam logic [3:0][3:0] ROW2_KEYS = {K9, K6, KCL, K3};
  localparam logic [3:0][3:0] ROW3_KEYS = {K8, K5, KEN, K2};
  localparam logic [3:0][2:0] ROW1_JOY  = {3'(JOY_LEFT), 3'(JOY_UP), 3'(JOY_RIGHT), 3'(JOY_DOWN)};
  localparam int ROW3_FIRE_BIT = 1;

  typedef struct packed {
    logic       hit;
    logic       pad;
    logic [3:0] idx;
  } key_map_t;

  function automatic key_map_t km(input logic pad, input logic [3:0] idx);
    key_map_t m;
    m.hit = 1'b1;
    m.pad = pad;
    m.idx = idx;
    return m;
  endfunction

  function automatic key_map_t key_lookup(input logic [7:0] code);
    key_map_t m;
    m = '0;
    case (code)
      8'h69: m = km(1'b0, K1);
      8'h72: m = km(1'b0, K2);
      8'h7A: m = km(1'b0, K3);
      8'h6B: m = km(1'b0, K4);
      8'h73: m = km(1'b0, K5);
      8'h74: m = km(1'b0, K6);
      8'h6C: m = km(1'b0, K7);
      8'h75: m = km(1'b0, K8);
      8'h7D: m = km(1'b0, K9);
      8'h71: m = km(1'b0, KCL);
      8'h70: m = km(1'b0, K0);
      8'h5A: m = km(1'b0, KEN);
      8'h16: m = km(1'b1, K1);
      8'h1E: m = km(1'b1, K2);
      8'h26: m = km(1'b1, K3);
      8'h15: m = km(1'b1, K4);
      8'h1D: m = km(1'b1, K5);
      8'h24: m = km(1'b1, K6);
      8'h1C: m = km(1'b1, K7);
      8'h1B: m = km(1'b1, K8);
      8'h23: m = km(1'b1, K9);
      8'h1A: m = km(1'b1, KCL);
      8'h22: m = km(1'b1, K0);
      8'h21: m = km(1'b1, KEN);
      // Top-row digit aliases for pad 1.
      8'h25: m = km(1'b1, K4);
      8'h2E: m = km(1'b1, K5);
      8'h36: m = km(1'b1, K6);
      8'h3D: m = km(1'b1, K7);
      8'h3E: m = km(1'b1, K8);
      8'h46: m = km(1'b1, K9);
      8'h45: m = km(1'b1, K0);
      8'h4E: m = km(1'b1, KCL);
      8'h55: m = km(1'b1, KEN);
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/apf_keypad_matrix_debounce.sv
// One joystick bit: 2-FF synchroniser then a stability counter; the accepted
// state flips after DEBOUNCE_CYCLES consecutive differing samples (0 = sync only).
module apf_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign dout = sync_q;
    end else begin : g_filter
      localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
      localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic          state_q, state_d;
      logic [CW-1:0] cnt_q, cnt_d;

      always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        if (sync_q != state_q) begin
          if (cnt_q == CNT_LAST) begin
            state_d = sync_q;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      always_ff @(posedge clk_sys) begin
        if (reset) begin
          state_q <= 1'b0;
          cnt_q   <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
        end
      end

      assign dout = state_q;
    end
  endgenerate

endmodule

// File: rtl/apf_keypad_matrix.sv
// MP1000 keypad/joystick matrix: PS/2 key state plus debounced joysticks, answering
// PIA row strobes with registered active-low columns. APF_KEYPAD_AUTOFIRE_EN adds autofire.
module apf_keypad_matrix
  import apf_keypad_pkg::*;
#(
  parameter  int NUM_PADS        = 2,
  parameter  int ROWS            = 4,
  parameter  int DEBOUNCE_CYCLES = 16,
  localparam int COLS            = NUM_PADS * 4
) (
  input  logic                         clk_sys,
  input  logic                         reset,
  input  logic [10:0]                  ps2_key,
  input  logic [NUM_PADS*JOY_BITS-1:0] joy,
  input  logic [ROWS-1:0]              row_sel_n,
`ifdef APF_KEYPAD_AUTOFIRE_EN
  input  logic [NUM_PADS-1:0]          autofire,
`endif
  output logic [COLS-1:0]              col_n,
  output logic                         key_event
);

  logic [NUM_PADS-1:0][NUM_KEYS-1:0] key_q, key_d;
  logic                              tog_q;
  logic                              evt_q, evt_d;
  logic [COLS-1:0]                   col_q, col_d;
  logic [NUM_PADS*JOY_BITS-1:0]      joy_db;
  logic [NUM_PADS-1:0]               fire_eff;
  logic [3:0][COLS-1:0]              row_dat;
  key_map_t                          map;
  logic                              take;

  for (genvar i = 0; i < NUM_PADS * JOY_BITS; i++) begin : g_joy
    apf_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_sys(clk_sys),
      .reset  (reset),
      .din    (joy[i]),
      .dout   (joy_db[i])
    );
  end

`ifdef APF_KEYPAD_AUTOFIRE_EN
  logic [19:0] div_q, div_d;

  assign div_d = div_q + 20'd1;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  always_comb begin
    fire_eff = '0;
    for (int p = 0; p < NUM_PADS; p++) begin
      fire_eff[p] = joy_db[p*JOY_BITS + JOY_FIRE] & (~autofire[p] | div_q[19]);
    end
  end
`else
  always_comb begin
    fire_eff = '0;
    for (int p = 0; p < NUM_PADS; p++) begin
      fire_eff[p] = joy_db[p*JOY_BITS + JOY_FIRE];
    end
  end
`endif

  // A toggle on ps2_key[10] marks a new scancode; only mapped, non-extended codes land.
  always_comb begin
    map   = key_lookup(ps2_key[7:0]);
    take  = (ps2_key[10] != tog_q) && !ps2_key[8] && map.hit && (int'(map.pad) < NUM_PADS);
    key_d = key_q;
    evt_d = 1'b0;
    if (take) begin
      key_d[map.pad][map.idx] = ~ps2_key[9];
      evt_d                   = 1'b1;
    end
  end

  always_comb begin
    row_dat = '1;
    for (int p = 0; p < NUM_PADS; p++) begin
      for (int b = 0; b < 4; b++) begin
        row_dat[ROW_KEYS_A][p*4 + b] = key_q[p][ROW0_KEYS[b]];
        row_dat[ROW_JOY][p*4 + b]    = ~joy_db[p*JOY_BITS + int'(ROW1_JOY[b])];
        row_dat[ROW_KEYS_B][p*4 + b] = key_q[p][ROW2_KEYS[b]];
        row_dat[ROW_KEYS_C][p*4 + b] = key_q[p][ROW3_KEYS[b]];
      end
      row_dat[ROW_KEYS_C][p*4 + ROW3_FIRE_BIT] = key_q[p][KEN] & ~fire_eff[p];
    end

    // Selected rows wire-AND; undefined rows contribute all ones.
    col_d = '1;
    for (int r = 0; r < ROWS; r++) begin
      if (!row_sel_n[r] && (r < DEF_ROWS)) begin
        col_d &= row_dat[r[1:0]];
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      key_q <= '1;
      tog_q <= ps2_key[10];
      evt_q <= 1'b0;
      col_q <= '1;
    end else begin
      key_q <= key_d;
      tog_q <= ps2_key[10];
      evt_q <= evt_d;
      col_q <= col_d;
    end
  end

  assign col_n     = col_q;
  assign key_event = evt_q;

endmodule

// File: tb/tb_apf_keypad_matrix.sv
// Bench for apf_keypad_matrix: directed cases with literal expectations, then random
// PS/2, row and joystick traffic checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_apf_keypad_matrix;

  localparam int NP   = 2;
  localparam int NR   = 4;
  localparam int DB   = 16;
  localparam int NC   = NP * 4;
  localparam int NJ   = NP * 5;
  localparam int NMAP = 33;

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic [10:0]   ps2_key = '0;
  logic [NJ-1:0] joy = '0;
  logic [NR-1:0] row_sel_n = '1;
  logic [NC-1:0] col_n;
  logic          key_event;
`ifdef APF_KEYPAD_AUTOFIRE_EN
  logic [NP-1:0] autofire = '0;
`endif

  always #5 clk_sys = ~clk_sys;

  apf_keypad_matrix #(
    .NUM_PADS(NP),
    .ROWS(NR),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ps2_key  (ps2_key),
    .joy      (joy),
    .row_sel_n(row_sel_n),
`ifdef APF_KEYPAD_AUTOFIRE_EN
    .autofire (autofire),
`endif
    .col_n    (col_n),
    .key_event(key_event)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Key numbering: 0-9 digits, 10 = clear/*, 11 = enter/#.
  logic [7:0] map_code [NMAP] = '{
    8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D, 8'h71, 8'h70, 8'h5A,
    8'h16, 8'h1E, 8'h26, 8'h15, 8'h1D, 8'h24, 8'h1C, 8'h1B, 8'h23, 8'h1A, 8'h22, 8'h21,
    8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45, 8'h4E, 8'h55};
  int map_pad [NMAP] = '{
    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
    1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1,
    1, 1, 1, 1, 1, 1, 1, 1, 1};
  int map_key [NMAP] = '{
    1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11,
    1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11,
    4, 5, 6, 7, 8, 9, 0, 10, 11};

  logic          m_rel [NP][12];
  logic [NJ-1:0] m_acc;
  logic [NJ-1:0] jq [$];
  logic          m_tog;
  logic [NC-1:0] exp_col;
  logic          exp_evt;
  bit            chk_en = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NC-1:0] model_col(input logic [NR-1:0] rs);
    logic [NC-1:0] rows [4];
    logic [NC-1:0] res;
    for (int p = 0; p < NP; p++) begin
      logic jr, jl, jd, ju, jf;
      jr = m_acc[p*5];
      jl = m_acc[p*5+1];
      jd = m_acc[p*5+2];
      ju = m_acc[p*5+3];
      jf = m_acc[p*5+4];
      rows[0][p*4 +: 4] = {m_rel[p][7], m_rel[p][4], m_rel[p][0], m_rel[p][1]};
      rows[1][p*4 +: 4] = {~jl, ~ju, ~jr, ~jd};
      rows[2][p*4 +: 4] = {m_rel[p][9], m_rel[p][6], m_rel[p][10], m_rel[p][3]};
      rows[3][p*4 +: 4] = {m_rel[p][8], m_rel[p][5], m_rel[p][11] & ~jf, m_rel[p][2]};
    end
    res = '1;
    for (int k = 0; k < NR; k++) begin
      if (!rs[k]) res &= rows[k];
    end
    return res;
  endfunction

  // Model: outputs after each edge are computed from state before it. A joystick
  // bit is accepted once the last DB synchronised samples (joy two edges late)
  // all disagree with the accepted value.
  always @(posedge clk_sys) begin
    if (reset) begin
      for (int p = 0; p < NP; p++)
        for (int k = 0; k < 12; k++) m_rel[p][k] = 1'b1;
      m_acc = '0;
      jq.delete();
      for (int i = 0; i < DB + 2; i++) jq.push_back('0);
      exp_col = '1;
      exp_evt = 1'b0;
    end else begin
      exp_col = model_col(row_sel_n);
      exp_evt = 1'b0;
      if (ps2_key[10] !== m_tog && !ps2_key[8]) begin
        for (int i = 0; i < NMAP; i++) begin
          if (map_code[i] == ps2_key[7:0]) begin
            m_rel[map_pad[i]][map_key[i]] = ~ps2_key[9];
            exp_evt = 1'b1;
          end
        end
      end
      jq.push_back(joy);
      void'(jq.pop_front());
      for (int b = 0; b < NJ; b++) begin
        bit all_diff;
        all_diff = 1'b1;
        for (int k = 0; k < DB; k++) begin
          if (jq[k][b] == m_acc[b]) all_diff = 1'b0;
        end
        if (all_diff) m_acc[b] = ~m_acc[b];
      end
    end
    m_tog = ps2_key[10];
  end

  always @(negedge clk_sys) begin
    if (chk_en) begin
      check("col_n", col_n, exp_col);
      check("key_event", {7'b0, key_event}, {7'b0, exp_evt});
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic ps2(input logic pressed, input logic ext, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pressed, ext, code};
  endtask

  task automatic lit(input string name, input logic [NC-1:0] ec, input logic ee);
    check({name, "_col"}, col_n, ec);
    check({name, "_model"}, exp_col, ec);
    check({name, "_evt"}, {7'b0, key_event}, {7'b0, ee});
  endtask

  initial begin
    reset     = 1'b1;
    row_sel_n = 4'b1110;
    step(3);
    reset = 1'b0;
    step(1);
    chk_en = 1'b1;
    lit("reset", 8'hFF, 1'b0);

    ps2(1'b1, 1'b0, 8'h69); step(1); lit("press1_evt", 8'hFF, 1'b1);
    step(1); lit("press1_col", 8'hFE, 1'b0);
    ps2(1'b0, 1'b0, 8'h69); step(2); lit("release1", 8'hFF, 1'b0);

    row_sel_n = 4'b0111;
    ps2(1'b1, 1'b0, 8'h21); joy[9] = 1'b1; step(24); lit("hash_fire", 8'hDF, 1'b0);
    ps2(1'b0, 1'b0, 8'h21); step(2); lit("fire_only", 8'hDF, 1'b0);
    ps2(1'b1, 1'b0, 8'h21); joy[9] = 1'b0; step(24); lit("hash_only", 8'hDF, 1'b0);
    ps2(1'b0, 1'b0, 8'h21); step(2); lit("pad1_clear", 8'hFF, 1'b0);

    row_sel_n = 4'b1101;
    joy[0] = 1'b1; step(5); joy[0] = 1'b0; step(25); lit("glitch5", 8'hFF, 1'b0);
    joy[0] = 1'b1; step(18); lit("joy_pre", 8'hFF, 1'b0);
    step(1); lit("joy_lat", 8'hFD, 1'b0);
    joy[0] = 1'b0; step(25);

    row_sel_n = 4'b1010;
    ps2(1'b1, 1'b0, 8'h69); step(1);
    ps2(1'b1, 1'b0, 8'h7A); step(2); lit("and_rows", 8'hFE, 1'b0);
    ps2(1'b1, 1'b0, 8'h6C); step(2); lit("and_rows7", 8'hF6, 1'b0);
    ps2(1'b0, 1'b1, 8'h69); step(1); lit("ext_evt", 8'hF6, 1'b0);
    step(1); lit("ext_col", 8'hF6, 1'b0);

    reset = 1'b1; step(1); lit("reset_mid", 8'hFF, 1'b0);
    reset = 1'b0; step(1); lit("post_reset", 8'hFF, 1'b0);

    for (int c = 0; c < 3000; c++) begin
      logic [7:0] code;
      reset = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 3) == 0) row_sel_n = 4'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 3) == 0) code = 8'($urandom);
        else code = map_code[$urandom_range(0, NMAP - 1)];
        ps2(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), code);
      end
      if ($urandom_range(0, 7) == 0) begin
        int unsigned jb;
        jb = $urandom_range(0, NJ - 1);
        joy[jb] = ~joy[jb];
      end
      step(1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
